// File: rtl/intra_pkg.sv
// Shared constants for the angular intra row generator: angle tables,
// the invalid-index marker and the sequencer state encoding.
package intra_pkg;

  // Indices 17..31 are invalid.
  localparam logic [4:0] ANG_INVALID = 5'd17;

  // Index 8 is the pure horizontal/vertical direction.
  localparam logic [4:0] ANG_ZERO_IDX = 5'd8;

  // intraPredAngle for angle indices 0..16.
  localparam logic signed [6:0] ANGLE_TABLE [0:16] = '{
    -7'sd2,  -7'sd5,  -7'sd9,  -7'sd13, -7'sd17, -7'sd21, -7'sd26, -7'sd32,
     7'sd0,
     7'sd2,   7'sd5,   7'sd9,   7'sd13,  7'sd17,  7'sd21,  7'sd26,  7'sd32
  };

  // invAngle exists only for negative angles (indices 0..7).
  localparam logic signed [12:0] INV_ANGLE_TABLE [0:7] = '{
    -13'sd4096, -13'sd1638, -13'sd910, -13'sd630,
    -13'sd482,  -13'sd390,  -13'sd315, -13'sd256
  };

  // Sequencer states, kept as plain constants so the encoding is fixed.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    GEN  = ST_GEN
  } state_e;

endpackage

// File: rtl/intra_angIdx_to_angle.sv
// Combinational decode of the 5-bit angle index into intraPredAngle,
// invAngle and a validity flag.
module intra_angIdx_to_angle
  import intra_pkg::*;
(
  input  logic [4:0]         ang,
  output logic signed [6:0]  angle,
  output logic signed [12:0] inv_angle,
  output logic               valid
);

  logic [4:0] safe_idx;

  // Table lookup; out-of-range indices are steered to the zero-angle entry.
  always_comb begin
    valid     = (ang < ANG_INVALID);
    safe_idx  = valid ? ang : ANG_ZERO_IDX;
    angle     = ANGLE_TABLE[safe_idx];
    inv_angle = (ang < ANG_ZERO_IDX) ? INV_ANGLE_TABLE[ang[2:0]] : '0;
  end

endmodule

// File: rtl/intra_ang_row_gen.sv
// Angular intra row generator: latches the decoded angle for a block, then
// walks N rows emitting (row_y, i_idx, i_fact, row_last) under a
// valid/ready handshake. acc always holds (row_y+1)*angle.
module intra_ang_row_gen
  import intra_pkg::*;
#(
  parameter int MAX_LOG2 = 5,
  parameter int ACC_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          ang,
  input  logic [2:0]          log2_size,
  output logic                busy,
  output logic                err,
  output logic signed [6:0]   angle,
  output logic signed [12:0]  inv_angle,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [MAX_LOG2-1:0] row_y,
  output logic signed [6:0]   i_idx,
  output logic [4:0]          i_fact,
  output logic                row_last
);

  localparam int CW = MAX_LOG2 + 1;

  logic [0:0]                state_reg;
  logic                      busy_reg;
  logic                      err_reg;
  logic signed [6:0]         angle_reg;
  logic signed [12:0]        inv_angle_reg;
  logic                      row_valid_reg;
  logic [MAX_LOG2-1:0]       row_y_reg;
  logic [MAX_LOG2-1:0]       n_last_reg;
  logic                      row_last_reg;
  logic signed [ACC_W-1:0]   acc_reg;

  logic signed [6:0]         dec_angle;
  logic signed [12:0]        dec_inv_angle;
  logic                      dec_valid;
  logic                      size_ok;
  logic [CW-1:0]             n_full;
  logic [MAX_LOG2-1:0]       n_last_next;
  logic [MAX_LOG2-1:0]       row_y_next;
  logic                      accept;

  intra_angIdx_to_angle u_dec (
    .ang       (ang),
    .angle     (dec_angle),
    .inv_angle (dec_inv_angle),
    .valid     (dec_valid)
  );

  // Request qualification and next-row helpers.
  always_comb begin
    size_ok     = (log2_size >= 3'd2) && (int'(log2_size) <= MAX_LOG2);
    n_full      = CW'(1) << log2_size;
    n_last_next = MAX_LOG2'(n_full - CW'(1));
    row_y_next  = row_y_reg + MAX_LOG2'(1);
    accept      = row_valid_reg && row_ready;
  end

  // Block sequencer: latch on a legal start, step rows on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      angle_reg     <= '0;
      inv_angle_reg <= '0;
      row_valid_reg <= 1'b0;
      row_y_reg     <= '0;
      n_last_reg    <= '0;
      row_last_reg  <= 1'b0;
      acc_reg       <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (dec_valid && size_ok) begin
              state_reg     <= ST_GEN;
              busy_reg      <= 1'b1;
              angle_reg     <= dec_angle;
              inv_angle_reg <= dec_inv_angle;
              n_last_reg    <= n_last_next;
              acc_reg       <= {{(ACC_W-7){dec_angle[6]}}, dec_angle};
              row_y_reg     <= '0;
              row_valid_reg <= 1'b1;
              // Smallest block is 4 rows, so row 0 is never the last.
              row_last_reg  <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_GEN: begin
          if (accept) begin
            if (row_y_reg == n_last_reg) begin
              state_reg     <= ST_IDLE;
              busy_reg      <= 1'b0;
              row_valid_reg <= 1'b0;
              row_last_reg  <= 1'b0;
            end else begin
              row_y_reg    <= row_y_next;
              acc_reg      <= acc_reg + {{(ACC_W-7){angle_reg[6]}}, angle_reg};
              row_last_reg <= (row_y_next == n_last_reg);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign err       = err_reg;
  assign angle     = angle_reg;
  assign inv_angle = inv_angle_reg;
  assign row_valid = row_valid_reg;
  assign row_y     = row_y_reg;
  assign row_last  = row_last_reg;
  // Arithmetic shift floors toward minus infinity; low 5 bits are the weight.
  assign i_idx     = 7'(acc_reg >>> 5);
  assign i_fact    = acc_reg[4:0];

endmodule

// File: doc/intra_ang_row_gen.md
Name: intra_ang_row_gen

Overview:
- Converts a 5-bit angle index (the team's 0..17 encoding) back into the HEVC intraPredAngle and invAngle.
- Then walks the rows (or columns) of an NxN prediction block, emitting per-row reference offset iIdx and interpolation weight iFact.
- Sits between the mode decoder and the angular sample interpolator; one row descriptor is emitted per accepted handshake.

Parameters:
- MAX_LOG2, 5, log2 of the largest supported block size (32).
- ACC_W, 12, signed accumulator width; must hold ±(2^MAX_LOG2)*32.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high, clears all state
- start  in  1  request pulse; sampled only in IDLE
- ang  in  5  angle index: 0..7 → -2,-5,-9,-13,-17,-21,-26,-32; 8 → 0; 9..16 → 2,5,9,13,17,21,26,32; 17..31 invalid
- log2_size  in  3  block size log2, legal 2..5
- busy  out  1  high while in GEN
- err  out  1  one-cycle pulse on an invalid start
- angle  out  7  signed intraPredAngle, held for the whole block
- inv_angle  out  13  signed invAngle: -4096,-1638,-910,-630,-482,-390,-315,-256 for indices 0..7; 0 otherwise
- row_valid  out  1  row descriptor valid
- row_ready  in  1  downstream accepts the row
- row_y  out  5  row number 0..N-1
- i_idx  out  7  signed, acc >>> 5
- i_fact  out  5  acc[4:0]
- row_last  out  1  marks row N-1

Behaviour:
- Reset values: all outputs 0; state IDLE; acc 0; row counter 0.
- States: IDLE, GEN.
- IDLE, start=1, legal ang (≤16) and legal log2_size:
  - latch angle, inv_angle, N = 1<<log2_size
  - acc ← angle (sign-extended to ACC_W); row_y ← 0
  - next cycle: GEN with row_valid=1. Latency start→first row_valid = 1 cycle.
- IDLE, start=1, invalid ang (≥17) or log2_size outside 2..5:
  - err=1 for exactly one cycle, next cycle
  - stay IDLE; angle, inv_angle and row outputs unchanged
- GEN: row_valid stays 1. All row outputs are stable while row_ready=0 (backpressure can last indefinitely).
- GEN, row_valid & row_ready:
  - if row_y == N-1: go IDLE, row_valid ← 0, row_last ← 0, busy ← 0
  - else: row_y+1, acc ← acc + angle
- Row fields:
  - i_idx = arithmetic right shift of acc by 5 (floor, so negative acc rounds toward −∞)
  - i_fact = acc & 31
  - row_last = (row_y == N-1)
- Arithmetic: acc always equals (row_y+1)*angle; max magnitude 1024 at N=32, angle ±32; no overflow at ACC_W=12.
- angle=0 (ang=8): all rows have i_idx=0, i_fact=0; inv_angle=0.
- Start while busy: ignored, no err.
- Back-to-back blocks: start may be asserted in the same cycle the last row is accepted. It is ignored because the block is not yet in IDLE. The earliest accepted start is the first IDLE cycle.
- Reset mid-block: immediate return to IDLE, row_valid drops asynchronously, and no partial continuation after reset.
- err and row_valid are never high together.

Decomposition:
- Shared package intra_pkg:
  - angle table (17 signed 7-bit constants)
  - invAngle table (8 signed 13-bit constants)
  - ANG_INVALID=17
  - state enum IDLE/GEN
- One combinational sub-module, intra_angIdx_to_angle: ang → angle, inv_angle, valid. Instantiated once at the latch point.
- Row sequencer, accumulator and handshake stay in the top.

Test Plan:
- ang=15, log2_size=2, row_ready=1 → angle=26, inv_angle=0; rows (i_idx,i_fact) = (0,26),(1,20),(2,14),(3,8); row_last on row 3; busy low on the next cycle.
- ang=0, log2_size=3 → angle=-2, inv_angle=-4096; all 8 rows i_idx=-1; i_fact = 30,28,26,24,22,20,18,16.
- ang=7, log2_size=5 → angle=-32, inv_angle=-256; row y gives i_idx=-(y+1), i_fact=0; row 31 gives i_idx=-32 with row_last=1.
- ang=12, log2_size=3, row_ready held low 3 cycles at row_y=2 → row_y=2, i_idx=1, i_fact=7 stable for all 3 cycles; row 3 = (1,20) after acceptance; exactly 8 rows total.
- ang=17 start, then ang=9 with log2_size=6 start → err pulses once each, busy stays 0, no row_valid.
- ang=16, log2_size=4, rst asserted during row 5 → all outputs 0 immediately. A fresh start after reset release restarts at row_y=0 with i_idx=1, i_fact=0.
